// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, receiver state encoding and byte classification helper.
`timescale 1ns/1ps
package ps2_pkg;

    localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PFX_REL   = 8'hF0;
    localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;
    localparam logic [7:0] PS2_BAT_OK    = 8'hAA;
    localparam logic [7:0] PS2_ACK       = 8'hFA;
    localparam logic [7:0] PS2_RESEND    = 8'hFE;
    localparam logic [7:0] PS2_ECHO      = 8'hEE;
    localparam logic [7:0] PS2_ERR_LO    = 8'h00;
    localparam logic [7:0] PS2_ERR_HI    = 8'hFF;

    // Bytes that follow E1 in the Pause make-sequence.
    localparam logic [2:0] PS2_PAUSE_SKIP = 3'd7;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } ps2_rx_state_e;

    function automatic logic ps2_is_noise(input logic [7:0] b);
        return (b == PS2_BAT_OK) || (b == PS2_ACK) || (b == PS2_RESEND) ||
               (b == PS2_ECHO) || (b == PS2_ERR_LO) || (b == PS2_ERR_HI);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus FILTER_LEN-sample deglitcher for one PS/2 line;
// emits a one-cycle pulse when the filtered line falls.
`timescale 1ns/1ps
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic fall_o
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(FILTER_LEN - 1);

    logic          sync1_q, sync2_q;
    logic          filt_q, filt_d;
    logic          fall_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Filtered level only moves after FILTER_LEN consecutive disagreeing samples.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = CNT_LOAD;
        if (sync2_q != filt_q) begin
            if (cnt_q == '0) filt_d = sync2_q;
            else             cnt_d  = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            cnt_q   <= CNT_LOAD;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= line_i;
            sync2_q <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
            fall_q  <= filt_q & ~filt_d;
        end
    end

    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_scancode_framer.sv
// PS/2 keyboard receiver: frames 11-bit packets, checks them, strips E0/F0/E1
// prefixes and strobes one {scan, extended, released} event per key.
`timescale 1ns/1ps
module ps2_scancode_framer
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2clk,
    input  logic       ps2data,
    output logic       scan_received,
    output logic [7:0] scan,
    output logic       extended,
    output logic       released,
    output logic       rx_error
);

    // state     | meaning
    // RX_IDLE   | waiting for a start bit (data=0 on a clock fall)
    // RX_DATA   | shifting in 8 data bits, LSB first
    // RX_PARITY | checking odd parity over data+parity
    // RX_STOP   | expecting stop bit = 1, byte accepted here

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 1);

    logic          clk_fall;
    logic          dsync1_q, dsync2_q;
    ps2_rx_state_e state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          rx_timeout, parity_ok, frame_err, byte_ok;
    logic          byte_vld_q, err_q;
    logic [7:0]    byte_q;
    logic          ext_q, ext_d, rel_q, rel_d;
    logic [2:0]    skip_q, skip_d;
    logic [7:0]    scan_q, scan_d;
    logic          extended_q, extended_d, released_q, released_d;
    logic          strobe_q, strobe_d;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk    (clk),
        .rst    (rst),
        .line_i (ps2clk),
        .fall_o (clk_fall)
    );

    // A fall in the same cycle as terminal count wins: the frame is still alive.
    assign rx_timeout = (state_q != RX_IDLE) && (tmo_q == '0) && !clk_fall;
    assign parity_ok  = ^{shift_q, dsync2_q};

    always_comb begin
        tmo_d = TMO_LOAD;
        if (!clk_fall && state_q != RX_IDLE && tmo_q != '0)
            tmo_d = tmo_q - TW'(1);
    end

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (rx_timeout) begin
            state_d = RX_IDLE;
        end else if (clk_fall) begin
            case (state_q)
                RX_IDLE: if (!dsync2_q) begin
                    state_d   = RX_DATA;
                    bit_cnt_d = 3'd0;
                end
                RX_DATA: begin
                    shift_d   = {dsync2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
                end
                RX_PARITY: state_d = parity_ok ? RX_STOP : RX_IDLE;
                RX_STOP:   state_d = RX_IDLE;
                default:   state_d = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        byte_ok   = clk_fall && (state_q == RX_STOP) && dsync2_q;
        frame_err = rx_timeout
                  || (clk_fall && (state_q == RX_PARITY) && !parity_ok)
                  || (clk_fall && (state_q == RX_STOP) && !dsync2_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dsync1_q   <= 1'b1;
            dsync2_q   <= 1'b1;
            state_q    <= RX_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            tmo_q      <= TMO_LOAD;
            byte_vld_q <= 1'b0;
            byte_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            dsync1_q   <= ps2data;
            dsync2_q   <= dsync1_q;
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            tmo_q      <= tmo_d;
            byte_vld_q <= byte_ok;
            err_q      <= frame_err;
            if (byte_ok) byte_q <= shift_q;
        end
    end

    always_comb begin
        ext_d      = ext_q;
        rel_d      = rel_q;
        skip_d     = skip_q;
        scan_d     = scan_q;
        extended_d = extended_q;
        released_d = released_q;
        strobe_d   = 1'b0;
        if (err_q) begin
            ext_d = 1'b0;
            rel_d = 1'b0;
        end else if (byte_vld_q) begin
            if (skip_q != '0) begin
                skip_d = skip_q - 3'd1;
            end else if (byte_q == PS2_PFX_EXT) begin
                ext_d = 1'b1;
            end else if (byte_q == PS2_PFX_REL) begin
                rel_d = 1'b1;
            end else if (byte_q == PS2_PFX_PAUSE) begin
                skip_d = PS2_PAUSE_SKIP;
                ext_d  = 1'b0;
                rel_d  = 1'b0;
            end else if (ps2_is_noise(byte_q)) begin
                ext_d = 1'b0;
                rel_d = 1'b0;
            end else begin
                scan_d     = byte_q;
                extended_d = ext_q;
                released_d = rel_q;
                strobe_d   = 1'b1;
                ext_d      = 1'b0;
                rel_d      = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ext_q      <= 1'b0;
            rel_q      <= 1'b0;
            skip_q     <= '0;
            scan_q     <= '0;
            extended_q <= 1'b0;
            released_q <= 1'b0;
            strobe_q   <= 1'b0;
        end else begin
            ext_q      <= ext_d;
            rel_q      <= rel_d;
            skip_q     <= skip_d;
            scan_q     <= scan_d;
            extended_q <= extended_d;
            released_q <= released_d;
            strobe_q   <= strobe_d;
        end
    end

    assign scan_received = strobe_q;
    assign scan          = scan_q;
    assign extended      = extended_q;
    assign released      = released_q;
    assign rx_error      = err_q;

endmodule

// File: tb/tb_ps2_scancode_framer.sv
// Bench for ps2_scancode_framer: directed key sequences plus a random byte stream,
// checked against a byte-level model of the prefix/pause/noise rules.
`timescale 1ns/1ps
module tb_ps2_scancode_framer;

    localparam int TIMEOUT_CYC = 2000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2clk = 1'b1;
    logic       ps2data = 1'b1;
    logic       scan_received;
    logic [7:0] scan;
    logic       extended;
    logic       released;
    logic       rx_error;

    ps2_scancode_framer #(.FILTER_LEN(8), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk           (clk),
        .rst           (rst),
        .ps2clk        (ps2clk),
        .ps2data       (ps2data),
        .scan_received (scan_received),
        .scan          (scan),
        .extended      (extended),
        .released      (released),
        .rx_error      (rx_error)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Event capture: {scan, extended, released} per strobe, and error-strobe cycles.
    logic [9:0] got_a [0:1023];
    int         got_n = 0;
    int         err_seen = 0;

    always @(negedge clk) begin
        if (scan_received) begin
            got_a[got_n] = {scan, extended, released};
            got_n = got_n + 1;
        end
        if (rx_error) err_seen = err_seen + 1;
    end

    // Reference model state.
    logic [9:0] exp_q[$];
    int         err_exp = 0;
    int         got_rd = 0;
    bit         m_ext = 0, m_rel = 0;
    int         m_skip = 0;
    logic [9:0] last_ev = '0;

    task automatic model_byte(input logic [7:0] b);
        if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_rel = 1;
        end else if (b == 8'hE1) begin
            m_skip = 7; m_ext = 0; m_rel = 0;
        end else if (b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'hEE ||
                     b == 8'h00 || b == 8'hFF) begin
            m_ext = 0; m_rel = 0;
        end else begin
            exp_q.push_back({b, m_ext, m_rel});
            last_ev = {b, m_ext, m_rel};
            m_ext = 0; m_rel = 0;
        end
    endtask

    // err_kind: 0 good, 1 bad parity, 2 bad stop. nbits < 11 truncates the frame.
    task automatic send_frame(input logic [7:0] b, input int err_kind, input int nbits);
        logic [10:0] bits;
        bits[0]    = 1'b0;
        bits[8:1]  = b;
        bits[9]    = (err_kind == 1) ? (^b) : ~(^b);
        bits[10]   = (err_kind == 2) ? 1'b0 : 1'b1;
        for (int k = 0; k < nbits; k++) begin
            ps2data = bits[k];
            repeat (15) @(posedge clk);
            ps2clk = 1'b0;
            repeat (30) @(posedge clk);
            ps2clk = 1'b1;
            repeat (15) @(posedge clk);
        end
        ps2data = 1'b1;
        repeat (100) @(posedge clk);
    endtask

    task automatic tx(input logic [7:0] b, input int err_kind);
        send_frame(b, err_kind, 11);
        if (err_kind != 0) begin
            err_exp++;
            m_ext = 0; m_rel = 0;
        end else begin
            model_byte(b);
        end
    endtask

    task automatic compare_events(input string tag);
        logic [9:0] e;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk({tag, "_count"}, 32'(got_n - got_rd), 32'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_rd < got_n) begin
                chk({tag, "_event"}, 32'(got_a[got_rd]), 32'(e));
                got_rd++;
            end
        end
        got_rd = got_n;
        chk({tag, "_errors"}, 32'(err_seen), 32'(err_exp));
        chk({tag, "_hold"}, 32'({scan, extended, released}), 32'(last_ev));
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_strobe"}, 32'(scan_received), 32'd0);
        chk({tag, "_scan"}, 32'(scan), 32'd0);
        chk({tag, "_ext"}, 32'(extended), 32'd0);
        chk({tag, "_rel"}, 32'(released), 32'd0);
        chk({tag, "_err"}, 32'(rx_error), 32'd0);
    endtask

    initial begin
        int         r;
        int         ek;
        logic [7:0] b;

        repeat (4) @(posedge clk);
        check_reset_outputs("rst0");
        rst = 1'b1;
        repeat (20) @(posedge clk);

        tx(8'h1C, 0);
        compare_events("t1_single");

        tx(8'hF0, 0); tx(8'h1C, 0);
        tx(8'hE0, 0); tx(8'hF0, 0); tx(8'h75, 0);
        compare_events("t2_prefix");

        tx(8'h1C, 1); tx(8'h1B, 0);
        compare_events("t3_parity");

        tx(8'hE0, 0); tx(8'h3A, 2); tx(8'h3A, 0);
        compare_events("t3b_stop");

        tx(8'hF0, 0);
        send_frame(8'h29, 0, 5);
        repeat (TIMEOUT_CYC + 5) @(posedge clk);
        err_exp++; m_ext = 0; m_rel = 0;
        tx(8'h29, 0);
        compare_events("t4_timeout");

        tx(8'hE1, 0); tx(8'h14, 0); tx(8'h77, 0); tx(8'hE1, 0);
        tx(8'hF0, 0); tx(8'h14, 0); tx(8'hF0, 0); tx(8'h77, 0);
        tx(8'h1C, 0);
        compare_events("t5_pause");

        tx(8'hE0, 0); tx(8'hAA, 0); tx(8'h5A, 0);
        compare_events("t5b_noise");

        tx(8'hE0, 0);
        send_frame(8'h75, 0, 6);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        check_reset_outputs("t6_rst");
        m_ext = 0; m_rel = 0; m_skip = 0; last_ev = '0;
        rst = 1'b1;
        repeat (20) @(posedge clk);
        tx(8'h75, 0);
        compare_events("t6_after_rst");

        for (int i = 0; i < 30; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2)      b = 8'hE0;
            else if (r < 4) b = 8'hF0;
            else            b = 8'($urandom_range(0, 255));
            ek = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 2)) : 0;
            tx(b, ek);
            if (i % 6 == 5) compare_events("rand");
        end
        compare_events("rand_end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
